pci_rr_arbiter: RTL and testbench

Central PCI bus arbiter for up to `N_MASTERS` initiators, with round-robin fairness, bus parking and dead-master timeout. It samples active-low `REQ#` lines and the bus `FRAME#`/`IRDY#` state, then drives one-hot active-low `GNT#`. Grant handover while the bus is idle always inserts one all-deasserted turnaround cycle. It replaces the fixed-priority arbiter in the PCI top level.

---
 rtl/pci_rr_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_pci_rr_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pci_rr_arbiter.sv
// Central PCI bus arbiter: round-robin grant over registered REQ#, bus parking,
// one-cycle turnaround between masters and revocation of grants from dead masters.
module pci_rr_arbiter #(
  parameter int N_MASTERS    = 4,
  parameter int PARK_ID      = 0,
  parameter int DEAD_TIMEOUT = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_MASTERS-1:0]         req_n,
  input  logic                         frame_n,
  input  logic                         irdy_n,
  output logic [N_MASTERS-1:0]         gnt_n,
  output logic [$clog2(N_MASTERS)-1:0] owner,
  output logic                         bus_idle,
  output logic                         parked,
  output logic                         timeout_pulse
);

  localparam int IDX_W = $clog2(N_MASTERS);
  localparam int TMR_W = $clog2(DEAD_TIMEOUT) + 1;
  localparam logic [IDX_W-1:0] PARK_IDX = IDX_W'(PARK_ID);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_MASTERS - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DEAD_TIMEOUT - 1);

  typedef enum logic [1:0] {ST_PARK, ST_GAP, ST_GRANT, ST_BUSY} state_t;

  state_t               state_q, state_d;
  logic                 tgt_park_q, tgt_park_d;
  logic [IDX_W-1:0]     tgt_id_q, tgt_id_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic [N_MASTERS-1:0] gnt_n_q, gnt_n_d;
  logic                 parked_q, parked_d;
  logic                 timeout_q, timeout_d;
  logic [N_MASTERS-1:0] req_q;
  logic                 frame_q, irdy_q;

  logic                 bus_idle_w;
  logic [N_MASTERS-1:0] owner_mask;
  logic [IDX_W:0]       pick, pick_m;

  // Returns {found, index} of the first low request after ptr, wrapping.
  function automatic logic [IDX_W:0] rr_pick(input logic [N_MASTERS-1:0] req,
                                             input logic [IDX_W-1:0] ptr);
    logic             found;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] ci;
    found = 1'b0;
    idx   = '0;
    for (int i = N_MASTERS; i >= 1; i--) begin
      ci = IDX_W'((int'(ptr) + i) % N_MASTERS);
      if (!req[ci]) begin
        found = 1'b1;
        idx   = ci;
      end
    end
    return {found, idx};
  endfunction

  assign bus_idle_w = frame_q & irdy_q;
  assign owner_mask = {{(N_MASTERS-1){1'b0}}, 1'b1} << owner_q;
  assign pick       = rr_pick(req_q, ptr_q);
  assign pick_m     = rr_pick(req_q | owner_mask, ptr_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_GAP;
      tgt_park_q <= 1'b1;
      tgt_id_q   <= PARK_IDX;
      ptr_q      <= LAST_IDX;
      owner_q    <= PARK_IDX;
      timer_q    <= '0;
      gnt_n_q    <= '1;
      parked_q   <= 1'b0;
      timeout_q  <= 1'b0;
      req_q      <= '1;
      frame_q    <= 1'b1;
      irdy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      tgt_park_q <= tgt_park_d;
      tgt_id_q   <= tgt_id_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      timer_q    <= timer_d;
      gnt_n_q    <= gnt_n_d;
      parked_q   <= parked_d;
      timeout_q  <= timeout_d;
      req_q      <= req_n;
      frame_q    <= frame_n;
      irdy_q     <= irdy_n;
    end
  end

  always_comb begin
    state_d    = state_q;
    tgt_park_d = tgt_park_q;
    tgt_id_d   = tgt_id_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    timer_d    = timer_q;
    timeout_d  = 1'b0;
    case (state_q)
      ST_PARK: begin
        if (!frame_q) begin
          state_d = ST_BUSY;
        end else if (pick[IDX_W] && bus_idle_w) begin
          if (pick[IDX_W-1:0] == PARK_IDX) begin
            state_d = ST_GRANT;
            ptr_d   = PARK_IDX;
            owner_d = PARK_IDX;
            timer_d = '0;
          end else begin
            state_d    = ST_GAP;
            tgt_park_d = 1'b0;
            tgt_id_d   = pick[IDX_W-1:0];
          end
        end
      end
      ST_GAP: begin
        if (tgt_park_q) begin
          state_d = ST_PARK;
          owner_d = PARK_IDX;
        end else begin
          state_d = ST_GRANT;
          ptr_d   = tgt_id_q;
          owner_d = tgt_id_q;
          timer_d = '0;
        end
      end
      ST_GRANT: begin
        if (!frame_q) begin
          state_d = ST_BUSY;
          timer_d = '0;
        end else if (req_q[owner_q] && bus_idle_w) begin
          // Withdrawal is checked before the timeout so it suppresses the pulse.
          if (pick[IDX_W]) begin
            state_d    = ST_GAP;
            tgt_park_d = 1'b0;
            tgt_id_d   = pick[IDX_W-1:0];
          end else if (owner_q == PARK_IDX) begin
            state_d = ST_PARK;
          end else begin
            state_d    = ST_GAP;
            tgt_park_d = 1'b1;
          end
        end else if (bus_idle_w) begin
          if (timer_q == TMR_LAST) begin
            timeout_d  = 1'b1;
            state_d    = ST_GAP;
            tgt_park_d = !pick_m[IDX_W];
            tgt_id_d   = pick_m[IDX_W] ? pick_m[IDX_W-1:0] : tgt_id_q;
          end else if (timer_q != '1) begin
            timer_d = timer_q + TMR_W'(1);
          end
        end
      end
      ST_BUSY: begin
        if (bus_idle_w) begin
          if (pick[IDX_W]) begin
            state_d = ST_GRANT;
            ptr_d   = pick[IDX_W-1:0];
            owner_d = pick[IDX_W-1:0];
            timer_d = '0;
          end else begin
            state_d = ST_PARK;
            owner_d = PARK_IDX;
          end
        end
      end
      default: begin
        state_d    = ST_GAP;
        tgt_park_d = 1'b1;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register together with it.
  always_comb begin
    gnt_n_d  = '1;
    parked_d = 1'b0;
    case (state_d)
      ST_PARK: begin
        gnt_n_d[PARK_IDX] = 1'b0;
        parked_d          = 1'b1;
      end
      ST_GRANT: gnt_n_d[owner_d] = 1'b0;
      default:  gnt_n_d = '1;
    endcase
  end

  assign gnt_n         = gnt_n_q;
  assign owner         = owner_q;
  assign bus_idle      = bus_idle_w;
  assign parked        = parked_q;
  assign timeout_pulse = timeout_q;

endmodule

// File: tb/tb_pci_rr_arbiter.sv
// Directed bench for pci_rr_arbiter: expected outputs are queued with their due
// cycle as stimulus is applied and compared when that cycle's outputs settle.
module tb_pci_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_n;
  logic       frame_n;
  logic       irdy_n;
  logic [3:0] gnt_n;
  logic [1:0] owner;
  logic       bus_idle;
  logic       parked;
  logic       timeout_pulse;

  int         vectors     = 0;
  int         miscompares = 0;
  int         cyc_cnt     = 0;
  logic [3:0] prev_gnt    = 4'b1111;

  int         q_at[$];
  string      q_tag[$];
  logic [8:0] q_val[$];

  always #5 clk = ~clk;

  pci_rr_arbiter #(
    .N_MASTERS   (4),
    .PARK_ID     (0),
    .DEAD_TIMEOUT(16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_n        (req_n),
    .frame_n      (frame_n),
    .irdy_n       (irdy_n),
    .gnt_n        (gnt_n),
    .owner        (owner),
    .bus_idle     (bus_idle),
    .parked       (parked),
    .timeout_pulse(timeout_pulse)
  );

  // Queue an expectation due d cycles from now, kept sorted by due cycle.
  task automatic expect_out(input int d, input string tag, input logic [3:0] g,
                            input int o, input logic p, input logic tp, input logic idle);
    int i;
    i = 0;
    while (i < q_at.size() && q_at[i] <= cyc_cnt + d) i++;
    q_at.insert(i, cyc_cnt + d);
    q_tag.insert(i, tag);
    q_val.insert(i, {g, 2'(o), p, tp, idle});
  endtask

  task automatic cyc();
    logic [8:0] obs;
    logic [8:0] ev;
    @(posedge clk);
    #1;
    cyc_cnt++;
    vectors++;
    assert ($onehot0(~gnt_n)) else begin
      miscompares++;
      $error("FAIL gnt_onehot: observed gnt_n=%b, required at most one bit low", gnt_n);
    end
    vectors++;
    assert (prev_gnt === 4'b1111 || gnt_n === 4'b1111 || gnt_n === prev_gnt) else begin
      miscompares++;
      $error("FAIL gnt_turnaround: observed gnt_n %b -> %b, required an all-ones cycle between masters",
             prev_gnt, gnt_n);
    end
    prev_gnt = gnt_n;
    obs = {gnt_n, owner, parked, timeout_pulse, bus_idle};
    while (q_at.size() > 0 && q_at[0] <= cyc_cnt) begin
      ev = q_val[0];
      vectors++;
      assert (q_at[0] == cyc_cnt && obs === ev) else begin
        miscompares++;
        $error("FAIL %s @cyc %0d: observed gnt_n=%b owner=%0d parked=%b pulse=%b idle=%b, expected gnt_n=%b owner=%0d parked=%b pulse=%b idle=%b",
               q_tag[0], cyc_cnt, obs[8:5], obs[4:3], obs[2], obs[1], obs[0],
               ev[8:5], ev[4:3], ev[2], ev[1], ev[0]);
      end
      void'(q_at.pop_front());
      void'(q_tag.pop_front());
      void'(q_val.pop_front());
    end
  endtask

  initial begin
    rst     = 1'b1;
    req_n   = 4'b1111;
    frame_n = 1'b1;
    irdy_n  = 1'b1;
    cyc();
    expect_out(1, "reset_state", 4'b1111, 0, 1'b0, 1'b0, 1'b1);
    cyc();

    // Release reset: one turnaround cycle, then park on master 0.
    rst = 1'b0;
    expect_out(1, "park_after_reset", 4'b1110, 0, 1'b1, 1'b0, 1'b1);
    expect_out(2, "park_idle", 4'b1110, 0, 1'b1, 1'b0, 1'b1);
    repeat (2) cyc();

    // Master 2 requests from park: gap then grant.
    req_n = 4'b1011;
    expect_out(1, "t2_still_parked", 4'b1110, 0, 1'b1, 1'b0, 1'b1);
    expect_out(2, "t2_gap", 4'b1111, 0, 1'b0, 1'b0, 1'b1);
    expect_out(3, "t2_grant2", 4'b1011, 2, 1'b0, 1'b0, 1'b1);
    repeat (3) cyc();

    // Master 2 withdraws with nobody else requesting: gap, then park.
    req_n = 4'b1111;
    expect_out(1, "t6_hold2", 4'b1011, 2, 1'b0, 1'b0, 1'b1);
    expect_out(2, "t6_gap", 4'b1111, 2, 1'b0, 1'b0, 1'b1);
    expect_out(3, "t6_park", 4'b1110, 0, 1'b1, 1'b0, 1'b1);
    repeat (3) cyc();

    // Master 1 granted but never frames; master 3 joins and wins after timeout.
    req_n = 4'b1101;
    expect_out(2, "t4_gap", 4'b1111, 0, 1'b0, 1'b0, 1'b1);
    expect_out(3, "t4_grant1", 4'b1101, 1, 1'b0, 1'b0, 1'b1);
    expect_out(18, "t4_before_timeout", 4'b1101, 1, 1'b0, 1'b0, 1'b1);
    expect_out(19, "t4_timeout", 4'b1111, 1, 1'b0, 1'b1, 1'b1);
    expect_out(20, "t4_grant3", 4'b0111, 3, 1'b0, 1'b0, 1'b1);
    repeat (3) cyc();
    req_n = 4'b0101;
    repeat (17) cyc();

    // Master 3 frames, reset lands mid-transaction.
    frame_n = 1'b0;
    irdy_n  = 1'b0;
    expect_out(2, "t5_busy", 4'b1111, 3, 1'b0, 1'b0, 1'b0);
    repeat (2) cyc();
    rst = 1'b1;
    expect_out(1, "t5_reset_abort", 4'b1111, 0, 1'b0, 1'b0, 1'b1);
    cyc();
    rst     = 1'b0;
    frame_n = 1'b1;
    irdy_n  = 1'b1;
    req_n   = 4'b1111;
    expect_out(1, "t5_park", 4'b1110, 0, 1'b1, 1'b0, 1'b1);
    cyc();

    // All four request and each runs a transaction: order 0,1,2,3,0.
    req_n = 4'b0000;
    expect_out(1, "t3_park", 4'b1110, 0, 1'b1, 1'b0, 1'b1);
    expect_out(2, "t3_grant_m0", 4'b1110, 0, 1'b0, 1'b0, 1'b1);
    repeat (2) cyc();
    for (int m = 0; m < 4; m++) begin
      int         nxt;
      logic [3:0] g;
      nxt = (m + 1) % 4;
      g   = ~(4'b0001 << nxt);
      expect_out(2, $sformatf("t3_busy_m%0d", m), 4'b1111, m, 1'b0, 1'b0, 1'b0);
      expect_out(6, $sformatf("t3_grant_m%0d", nxt), g, nxt, 1'b0, 1'b0, 1'b1);
      frame_n = 1'b0;
      irdy_n  = 1'b0;
      repeat (3) cyc();
      frame_n = 1'b1;
      cyc();
      irdy_n = 1'b1;
      repeat (2) cyc();
    end

    // Park master withdraws: straight to park, no gap.
    req_n = 4'b1111;
    expect_out(1, "park_owner_hold", 4'b1110, 0, 1'b0, 1'b0, 1'b1);
    expect_out(2, "park_owner_direct", 4'b1110, 0, 1'b1, 1'b0, 1'b1);
    repeat (2) cyc();

    // Parked master starts a transaction by itself.
    frame_n = 1'b0;
    irdy_n  = 1'b0;
    expect_out(2, "park_to_busy", 4'b1111, 0, 1'b0, 1'b0, 1'b0);
    repeat (2) cyc();
    frame_n = 1'b1;
    irdy_n  = 1'b1;
    expect_out(1, "busy_hold", 4'b1111, 0, 1'b0, 1'b0, 1'b1);
    expect_out(2, "busy_to_park", 4'b1110, 0, 1'b1, 1'b0, 1'b1);
    repeat (2) cyc();

    // Withdrawal coincides with the timeout edge: withdrawal wins, no pulse.
    req_n = 4'b1011;
    expect_out(2, "wt_gap", 4'b1111, 0, 1'b0, 1'b0, 1'b1);
    expect_out(3, "wt_grant2", 4'b1011, 2, 1'b0, 1'b0, 1'b1);
    expect_out(18, "wt_hold2", 4'b1011, 2, 1'b0, 1'b0, 1'b1);
    expect_out(19, "wt_withdraw_no_pulse", 4'b1111, 2, 1'b0, 1'b0, 1'b1);
    expect_out(20, "wt_park", 4'b1110, 0, 1'b1, 1'b0, 1'b1);
    repeat (17) cyc();
    req_n = 4'b1111;
    repeat (3) cyc();

    repeat (2) cyc();
    vectors++;
    assert (q_at.size() == 0) else begin
      miscompares++;
      $error("FAIL scoreboard_drain: observed %0d pending expectations, required 0", q_at.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
